mult_norm_round: RTL and testbench
==================================

Name: mult_norm_round

Overview:
- Post-multiply stage of the FPU multiply path, directly downstream of the segmented Karatsuba mantissa multiplier.
- Consumes the 2*SW-bit mantissa product, the pre-computed biased exponent sum and the result sign.
- Normalises, rounds per the selected rounding mode, detects overflow and underflow, and packs the IEEE-754 result.
- Two-stage valid/ready pipeline, full throughput, with backpressure.

Parameters:
- SW, 24, mantissa width including hidden bit (24 = single precision).
- EW, 8, exponent field width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block accepts a beat this cycle.
- product_i  in  2*SW  unsigned mantissa product, value in [1,4) scaled by 2^(2SW-2), or zero.
- exp_sum_i  in  EW+2  two's-complement biased exponent, exp_a+exp_b-bias.
- sign_i  in  1  result sign.
- rmode_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- result_o  out  1+EW+SW-1  packed {sign, exponent, fraction}.
- ovf_o  out  1  overflow flag, qualified by out_valid_o.
- unf_o  out  1  underflow flag, qualified by out_valid_o.
- inexact_o  out  1  inexact flag, qualified by out_valid_o.

Behaviour:
- Reset: v1=v2=0; out_valid_o=0; result_o, ovf_o, unf_o, inexact_o all 0; in_ready_o=0 while rst is high.
- Handshake:
  - adv2 = ~v2 | out_ready_i.
  - in_ready_o = (~v1 | adv2) & ~rst.
  - A beat is accepted when in_valid_i & in_ready_o.
  - out_valid_o = v2.
  - While out_valid_o & ~out_ready_i, result_o and all flags hold stable.
- Latency and throughput: accepted beat appears on out_valid_o 2 cycles later when unstalled; one beat per cycle sustained; no beat dropped or duplicated under any ready pattern.
- Stage 1 (normalise), registered:
  - If product_i[2SW-1]=1: M=product_i[2SW-1 -: SW], G=product_i[SW-1], S=|product_i[SW-2:0], E=exp_sum_i+1.
  - Else: M=product_i[2SW-2 -: SW], G=product_i[SW-2], S=|product_i[SW-3:0], E=exp_sum_i.
  - Z=(product_i==0).
  - Nonzero product with both top bits 0 is illegal input; it follows the else path with no further guarantee.
- Stage 2 (round and pack), registered:
  - Increment inc:
    - RNE: G&(S|M[0]).
    - RTZ: 0.
    - +inf: (G|S)&~sign.
    - -inf: (G|S)&sign.
  - Rounding carry: {c,Mr}=M+inc at SW+1 bits. If c=1, Mr=1<<(SW-1) and E=E+1.
  - Zero: Z → result {sign,0...}; all flags 0.
  - Overflow, E >= 2^EW-1 (signed compare): ovf=1, inexact=1. Result is:
    - RNE: ±inf.
    - RTZ: ±max finite.
    - +inf mode: +inf if positive, else -max.
    - -inf mode: -inf if negative, else +max.
  - Underflow, E <= 0: no subnormal support. Flush to signed zero, unf=1, inexact=1.
  - Normal: result {sign, E[EW-1:0], Mr[SW-2:0]}; inexact=G|S.
  - Overflow is tested after rounding carry.
- Simultaneous accept and drain in the same cycle is legal and loses no data.
- rst asserted mid-operation: both stages discard contents immediately (async); no output after release until new beats are accepted.

Test Plan:
- 1.0x1.0: product_i=48'h4000_0000_0000, exp_sum_i=127, sign 0, RNE, out_ready_i=1 → 2 cycles later result_o=32'h3F80_0000, all flags 0.
- 1.5x1.5: product_i=48'h9000_0000_0000, exp_sum_i=127 → result_o=32'h4010_0000 (2.25), inexact 0.
- Tie rounding: product_i=48'h4000_00C0_0000, exp_sum_i=127.
  - RNE → 32'h3F80_0002, inexact 1.
  - RTZ → 32'h3F80_0001.
  - -inf mode with sign 0 → 32'h3F80_0001.
- Overflow: product_i=48'h9000_0000_0000, exp_sum_i=254.
  - RNE → 32'h7F80_0000, ovf 1, inexact 1.
  - RTZ → 32'h7F7F_FFFF.
- Underflow/zero:
  - exp_sum_i=0, product_i=48'h4000_0000_0000, sign 1 → 32'h8000_0000, unf 1.
  - product_i=0 → signed zero, no flags.
- Backpressure and reset:
  - Hold out_ready_i=0 and offer 3 back-to-back beats → 2 accepted, in_ready_o drops, result_o stable.
  - Raise out_ready_i → results emerge in order, third beat accepted.
  - Assert rst mid-stream → out_valid_o=0 and in_ready_o=0 immediately; no stale result after release.

Source files
------------

// File: rtl/mult_norm_round.sv
// Post-multiply normalise / round / pack stage of the FPU multiply path.
// Two-stage valid/ready pipeline: stage 1 normalises, stage 2 rounds, classifies and packs.
module mult_norm_round #(
  parameter int SW = 24,
  parameter int EW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [2*SW-1:0]     product_i,
  input  logic [EW+1:0]       exp_sum_i,
  input  logic                sign_i,
  input  logic [1:0]          rmode_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [EW+SW-1:0]    result_o,
  output logic                ovf_o,
  output logic                unf_o,
  output logic                inexact_o
);

  typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_UP = 2'b10, RM_DN = 2'b11} rmode_t;

  // One spare exponent bit so the +1 from normalisation and rounding never wraps.
  localparam int XW = EW + 3;
  localparam logic signed [XW-1:0] E_OVF = XW'((1 << EW) - 1);

  logic                 v1, v2, adv2;
  logic [SW-1:0]        m1;
  logic                 g1, s1, z1, sign1;
  logic signed [XW-1:0] e1;
  rmode_t               rmode1;

  logic [SW-1:0]        m_n;
  logic                 g_n, s_n;
  logic signed [XW-1:0] e_n;

  logic                 inc, carry, ovf_inf;
  logic [SW-2:0]        frac;
  logic signed [XW-1:0] er;
  logic [EW+SW-1:0]     res_n;
  logic                 ovf_n, unf_n, inx_n;

  assign adv2        = ~v2 | out_ready_i;
  assign in_ready_o  = (~v1 | adv2) & ~rst;
  assign out_valid_o = v2;

  always_comb begin
    if (product_i[2*SW-1]) begin
      m_n = product_i[2*SW-1 -: SW];
      g_n = product_i[SW-1];
      s_n = |product_i[SW-2:0];
      e_n = {exp_sum_i[EW+1], exp_sum_i} + XW'(1);
    end else begin
      m_n = product_i[2*SW-2 -: SW];
      g_n = product_i[SW-2];
      s_n = |product_i[SW-3:0];
      e_n = {exp_sum_i[EW+1], exp_sum_i};
    end
  end

  always_comb begin
    inc     = 1'b0;
    ovf_inf = 1'b1;
    case (rmode1)
      RM_RNE: begin inc = g1 & (s1 | m1[0]);  ovf_inf = 1'b1;   end
      RM_RTZ: begin inc = 1'b0;               ovf_inf = 1'b0;   end
      RM_UP:  begin inc = (g1 | s1) & ~sign1; ovf_inf = ~sign1; end
      RM_DN:  begin inc = (g1 | s1) & sign1;  ovf_inf = sign1;  end
      default: ;
    endcase
    // Carry out of M+inc only when M is all ones; the fraction then wraps to zero,
    // which matches renormalising to 1.0 with the exponent bumped.
    carry = inc & (&m1);
    frac  = m1[SW-2:0] + (SW-1)'(inc);
    er    = e1 + XW'(carry);

    res_n = '0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    inx_n = 1'b0;
    if (z1) begin
      res_n = {sign1, {(EW+SW-1){1'b0}}};
    end else if (er >= E_OVF) begin
      ovf_n = 1'b1;
      inx_n = 1'b1;
      if (ovf_inf) res_n = {sign1, {EW{1'b1}}, {(SW-1){1'b0}}};
      else         res_n = {sign1, {(EW-1){1'b1}}, 1'b0, {(SW-1){1'b1}}};
    end else if (er <= XW'(0)) begin
      unf_n = 1'b1;
      inx_n = 1'b1;
      res_n = {sign1, {(EW+SW-1){1'b0}}};
    end else begin
      inx_n = g1 | s1;
      res_n = {sign1, er[EW-1:0], frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      m1        <= '0;
      g1        <= 1'b0;
      s1        <= 1'b0;
      z1        <= 1'b0;
      sign1     <= 1'b0;
      e1        <= '0;
      rmode1    <= RM_RNE;
      result_o  <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
      inexact_o <= 1'b0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          result_o  <= res_n;
          ovf_o     <= ovf_n;
          unf_o     <= unf_n;
          inexact_o <= inx_n;
        end
      end
      if (in_ready_o) begin
        v1 <= in_valid_i;
        if (in_valid_i) begin
          m1     <= m_n;
          g1     <= g_n;
          s1     <= s_n;
          z1     <= (product_i == '0);
          sign1  <= sign_i;
          e1     <= e_n;
          rmode1 <= rmode_t'(rmode_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_norm_round.sv
// Directed bench for mult_norm_round: rounding, overflow/underflow, backpressure and reset.
module tb_mult_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] product = '0;
  logic [9:0]  exp_sum = '0;
  logic        sign = 1'b0;
  logic [1:0]  rmode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        ovf, unf, inexact;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_norm_round #(.SW(24), .EW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .product_i(product), .exp_sum_i(exp_sum), .sign_i(sign), .rmode_i(rmode),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .ovf_o(ovf), .unf_o(unf), .inexact_o(inexact)
  );

  typedef struct {
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    logic [1:0]  rm;
    logic [31:0] r;
    logic [2:0]  f;   // {ovf, unf, inexact}
  } vec_t;

  task automatic drive_beat(input logic [47:0] p, input logic [9:0] e, input logic s, input logic [1:0] rm);
    product = p; exp_sum = e; sign = s; rmode = rm; in_valid = 1'b1;
  endtask

  // Offer one beat with out_ready high and wait for its result; no checking here.
  task automatic run_beat(input vec_t v, output logic [31:0] r, output logic [2:0] f,
                          output int lat, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive_beat(v.p, v.e, v.s, v.rm);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!out_valid) ok = 1'b0;
    r = result;
    f = {ovf, unf, inexact};
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, result, ovf, unf, inexact} !== '0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h f=%b%b%b required all 0",
               in_ready, out_valid, result, ovf, unf, inexact);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors();
    vec_t vt[18];
    logic [31:0] r;
    logic [2:0]  f;
    int lat;
    bit ok;
    vt[0]  = '{48'h4000_0000_0000, 10'd127, 1'b0, 2'b00, 32'h3F80_0000, 3'b000};
    vt[1]  = '{48'h9000_0000_0000, 10'd127, 1'b0, 2'b00, 32'h4010_0000, 3'b000};
    vt[2]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 2'b00, 32'h3F80_0002, 3'b001};
    vt[3]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 2'b01, 32'h3F80_0001, 3'b001};
    vt[4]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 2'b11, 32'h3F80_0001, 3'b001};
    vt[5]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 2'b10, 32'h3F80_0002, 3'b001};
    vt[6]  = '{48'h4000_0040_0000, 10'd127, 1'b0, 2'b00, 32'h3F80_0000, 3'b001};
    vt[7]  = '{48'h7FFF_FFC0_0000, 10'd127, 1'b0, 2'b00, 32'h4000_0000, 3'b001};
    vt[8]  = '{48'h9000_0000_0000, 10'd254, 1'b0, 2'b00, 32'h7F80_0000, 3'b101};
    vt[9]  = '{48'h9000_0000_0000, 10'd254, 1'b0, 2'b01, 32'h7F7F_FFFF, 3'b101};
    vt[10] = '{48'h9000_0000_0000, 10'd254, 1'b1, 2'b10, 32'hFF7F_FFFF, 3'b101};
    vt[11] = '{48'h9000_0000_0000, 10'd254, 1'b1, 2'b11, 32'hFF80_0000, 3'b101};
    vt[12] = '{48'h9000_0000_0000, 10'd253, 1'b0, 2'b00, 32'h7F10_0000, 3'b000};
    vt[13] = '{48'h7FFF_FFC0_0000, 10'd254, 1'b0, 2'b00, 32'h7F80_0000, 3'b101};
    vt[14] = '{48'h4000_0000_0000, 10'd0,   1'b1, 2'b00, 32'h8000_0000, 3'b011};
    vt[15] = '{48'h0000_0000_0000, 10'd127, 1'b1, 2'b00, 32'h8000_0000, 3'b000};
    vt[16] = '{48'h4000_0000_0000, 10'd1,   1'b0, 2'b00, 32'h0080_0000, 3'b000};
    vt[17] = '{48'h9000_0000_0000, 10'h3FF, 1'b0, 2'b00, 32'h0000_0000, 3'b011};
    for (int i = 0; i < 18; i++) begin
      run_beat(vt[i], r, f, lat, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL vec%0d_timeout: got no handshake within 20 cycles required a result", i);
        continue;
      end
      tests++;
      if (r !== vt[i].r) begin
        fails++;
        $display("FAIL vec%0d_result: got %h required %h", i, r, vt[i].r);
      end
      tests++;
      if (f !== vt[i].f) begin
        fails++;
        $display("FAIL vec%0d_flags(ovf,unf,inx): got %b required %b", i, f, vt[i].f);
      end
      tests++;
      if (lat !== 2) begin
        fails++;
        $display("FAIL vec%0d_latency: got %0d required 2", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] ps[4];
    logic [31:0] exp_r[4];
    ps[0] = 48'h4000_0000_0000; exp_r[0] = 32'h3F80_0000;
    ps[1] = 48'h9000_0000_0000; exp_r[1] = 32'h4010_0000;
    ps[2] = 48'h4000_00C0_0000; exp_r[2] = 32'h3F80_0002;
    ps[3] = 48'h7FFF_FFC0_0000; exp_r[3] = 32'h4000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        drive_beat(ps[i], 10'd127, 1'b0, 2'b00);
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready%0d: got %b required 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2) begin
        tests++;
        if (out_valid !== 1'b1 || result !== exp_r[i-2]) begin
          fails++;
          $display("FAIL b2b_out%0d: got vld=%b res=%h required vld=1 res=%h",
                   i - 2, out_valid, result, exp_r[i-2]);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: got vld=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    @(negedge clk);
    out_ready = 1'b0;
    drive_beat(48'h4000_0000_0000, 10'd127, 1'b0, 2'b00);   // A -> 3F800000
    @(negedge clk);
    drive_beat(48'h9000_0000_0000, 10'd127, 1'b0, 2'b00);   // B -> 40100000
    @(negedge clk);
    drive_beat(48'h4000_00C0_0000, 10'd127, 1'b0, 2'b00);   // C -> 3F800002
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'h3F80_0000) begin
      fails++;
      $display("FAIL bp_full: got rdy=%b vld=%b res=%h required rdy=0 vld=1 res=3f800000",
               in_ready, out_valid, result);
    end
    held = result;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== held || inexact !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold: got rdy=%b vld=%b res=%h inx=%b required rdy=0 vld=1 res=%h inx=0",
               in_ready, out_valid, result, inexact, held);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || result !== 32'h4010_0000) begin
      fails++;
      $display("FAIL bp_second: got vld=%b res=%h required vld=1 res=40100000", out_valid, result);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || result !== 32'h3F80_0002 || inexact !== 1'b1) begin
      fails++;
      $display("FAIL bp_third: got vld=%b res=%h inx=%b required vld=1 res=3f800002 inx=1",
               out_valid, result, inexact);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: got vld=%b required 0", out_valid);
    end
  endtask

  task automatic test_midstream_reset();
    bit stale;
    @(negedge clk);
    out_ready = 1'b0;
    drive_beat(48'h9000_0000_0000, 10'd127, 1'b0, 2'b00);
    @(negedge clk);
    drive_beat(48'h4000_0000_0000, 10'd127, 1'b0, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_prefill: got vld=%b required 1", out_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0) begin
      fails++;
      $display("FAIL rst_async: got vld=%b rdy=%b res=%h required vld=0 rdy=0 res=00000000",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    tests++;
    if (stale) begin
      fails++;
      $display("FAIL rst_no_stale: got out_valid=1 after release required 0");
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

endmodule
